dmem_ctrl: RTL and testbench

//  Data-memory access controller for the MEM stage. Turns one MEM-stage load/store into a single SRAM-like

---
 rtl/dmem_pkg.sv | 50 +++++
 rtl/dmem_align.sv | 61 ++++++
 rtl/dmem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory controller.
//   op encodings, bus size codes, FSM state enum and small decode helpers.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned SIZE_W = 2;

    // op_mem[2] = store, op_mem[1:0] = access size + 1 (00 = no access)
    localparam logic [OP_W-1:0] OP_NONE = 3'b000;
    localparam logic [OP_W-1:0] OP_LB   = 3'b001;
    localparam logic [OP_W-1:0] OP_LH   = 3'b010;
    localparam logic [OP_W-1:0] OP_LW   = 3'b011;
    localparam logic [OP_W-1:0] OP_SB   = 3'b101;
    localparam logic [OP_W-1:0] OP_SH   = 3'b110;
    localparam logic [OP_W-1:0] OP_SW   = 3'b111;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Any non-zero size field means a real memory access.
    function automatic logic op_is_access(input logic [1:0] code);
        return code != 2'b00;
    endfunction

    function automatic logic [SIZE_W-1:0] op_size(input logic [1:0] code);
        return SIZE_W'(code - 2'd1);
    endfunction

    function automatic logic is_misaligned(input logic [SIZE_W-1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_HALF: bad = lo[0];
            SIZE_WORD: bad = (lo != 2'b00);
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane logic for the data-memory controller (purely combinational).
//   st_*  : byte strobes and lane-replicated write data for a store.
//   ld_*  : lane selection and sign/zero extension of a word-aligned read.
module dmem_align
    import dmem_pkg::*;
(
    input  logic              st_is_store,
    input  logic [SIZE_W-1:0] st_size,
    input  logic [1:0]        st_addr_lo,
    input  logic [WORD_W-1:0] st_src,
    output logic [STRB_W-1:0] st_wstrb,
    output logic [WORD_W-1:0] st_wdata,
    input  logic [SIZE_W-1:0] ld_size,
    input  logic [1:0]        ld_addr_lo,
    input  logic              ld_unsigned,
    input  logic [WORD_W-1:0] ld_rdata,
    output logic [WORD_W-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store strobes/data; reads carry no strobes.
    always_comb begin
        st_wstrb = '0;
        st_wdata = '0;
        if (st_is_store) begin
            case (st_size)
                SIZE_BYTE: begin
                    st_wstrb = STRB_W'(4'b0001 << st_addr_lo);
                    st_wdata = {4{st_src[7:0]}};
                end
                SIZE_HALF: begin
                    st_wstrb = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{st_src[15:0]}};
                end
                default: begin
                    st_wstrb = 4'b1111;
                    st_wdata = st_src;
                end
            endcase
        end
    end

    // Load lane select and extension.
    always_comb begin
        case (ld_addr_lo)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_size)
            SIZE_BYTE: ld_data = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_data = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default:   ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory access controller.
//   Pipeline side: op_mem/unsigned_mem/addr_mem/wdata_mem/flush in; stall_mem, addr_err,
//                  load_valid, load_data out.
//   Bus side     : SRAM-like data_req/wr/size/addr/wstrb/wdata out; data_addr_ok,
//                  data_data_ok, data_rdata in.
// One op becomes one bus transaction; the pipeline is stalled until it finishes.
// DATA_W must be 32.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   op_mem,
    input  logic              unsigned_mem,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic [DATA_W-1:0] wdata_mem,
    input  logic              flush,
    output logic              stall_mem,
    output logic              addr_err,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              data_req,
    output logic              data_wr,
    output logic [SIZE_W-1:0] data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [STRB_W-1:0] data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    state_e            state_q, state_d;
    logic              data_req_q, data_req_d;
    logic              data_wr_q, data_wr_d;
    logic [SIZE_W-1:0] data_size_q, data_size_d;
    logic [ADDR_W-1:0] data_addr_q, data_addr_d;
    logic [STRB_W-1:0] data_wstrb_q, data_wstrb_d;
    logic [DATA_W-1:0] data_wdata_q, data_wdata_d;
    logic              unsigned_q, unsigned_d;
    logic              discard_q, discard_d;
    logic              load_valid_q, load_valid_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;

    logic              access_c;
    logic [SIZE_W-1:0] size_c;
    logic              start_c;
    logic              resp_c;
    logic              drop_c;
    logic [STRB_W-1:0] st_wstrb_c;
    logic [DATA_W-1:0] st_wdata_c;
    logic [DATA_W-1:0] ld_data_c;

    assign access_c = op_is_access(op_mem[1:0]);
    assign size_c   = op_size(op_mem[1:0]);
    assign addr_err = access_c && is_misaligned(size_c, addr_mem[1:0]);
    assign start_c  = (state_q == ST_IDLE) && access_c && !addr_err && !flush;

    // Stall from the very first cycle an op is seen, through REQ and WAIT.
    assign stall_mem = start_c || (state_q == ST_REQ) || (state_q == ST_WAIT);

    // Store lanes come from the live op; load extraction from the latched request.
    dmem_align u_align (
        .st_is_store (op_mem[2]),
        .st_size     (size_c),
        .st_addr_lo  (addr_mem[1:0]),
        .st_src      (wdata_mem),
        .st_wstrb    (st_wstrb_c),
        .st_wdata    (st_wdata_c),
        .ld_size     (data_size_q),
        .ld_addr_lo  (data_addr_q[1:0]),
        .ld_unsigned (unsigned_q),
        .ld_rdata    (data_rdata),
        .ld_data     (ld_data_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        data_req_d   = 1'b0;
        data_wr_d    = data_wr_q;
        data_size_d  = data_size_q;
        data_addr_d  = data_addr_q;
        data_wstrb_d = data_wstrb_q;
        data_wdata_d = data_wdata_q;
        unsigned_d   = unsigned_q;
        discard_d    = discard_q;
        load_valid_d = 1'b0;
        load_data_d  = load_data_q;
        resp_c       = 1'b0;
        drop_c       = discard_q || flush;

        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d      = ST_REQ;
                    data_req_d   = 1'b1;
                    data_wr_d    = op_mem[2];
                    data_size_d  = size_c;
                    data_addr_d  = addr_mem;
                    data_wstrb_d = st_wstrb_c;
                    data_wdata_d = st_wdata_c;
                    unsigned_d   = unsigned_mem || (size_c == SIZE_WORD);
                    discard_d    = 1'b0;
                end
            end
            ST_REQ: begin
                if (data_addr_ok) begin
                    // Accepted: must run to completion even if flushed now.
                    if (data_data_ok) begin
                        resp_c = 1'b1;
                    end else begin
                        state_d   = ST_WAIT;
                        discard_d = flush;
                    end
                end else if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    data_req_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (data_data_ok) begin
                    resp_c = 1'b1;
                end else begin
                    discard_d = drop_c;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Response handling shared by REQ (same-cycle data_ok) and WAIT.
        if (resp_c) begin
            discard_d = 1'b0;
            if (drop_c) begin
                state_d = ST_IDLE;
            end else begin
                state_d      = ST_DONE;
                load_valid_d = !data_wr_q;
                if (!data_wr_q) begin
                    load_data_d = ld_data_c;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            data_req_q   <= 1'b0;
            data_wr_q    <= 1'b0;
            data_size_q  <= '0;
            data_addr_q  <= '0;
            data_wstrb_q <= '0;
            data_wdata_q <= '0;
            unsigned_q   <= 1'b0;
            discard_q    <= 1'b0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            data_req_q   <= data_req_d;
            data_wr_q    <= data_wr_d;
            data_size_q  <= data_size_d;
            data_addr_q  <= data_addr_d;
            data_wstrb_q <= data_wstrb_d;
            data_wdata_q <= data_wdata_d;
            unsigned_q   <= unsigned_d;
            discard_q    <= discard_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
        end
    end

    assign data_req   = data_req_q;
    assign data_wr    = data_wr_q;
    assign data_size  = data_size_q;
    assign data_addr  = data_addr_q;
    assign data_wstrb = data_wstrb_q;
    assign data_wdata = data_wdata_q;
    assign load_valid = load_valid_q;
    assign load_data  = load_data_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized transactions
// checked against a byte-lane reference model.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  op_mem;
    logic        unsigned_mem;
    logic [31:0] addr_mem;
    logic [31:0] wdata_mem;
    logic        flush;
    logic        stall_mem;
    logic        addr_err;
    logic        load_valid;
    logic [31:0] load_data;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int checks   = 0;
    int failures = 0;

    dmem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_mem       (op_mem),
        .unsigned_mem (unsigned_mem),
        .addr_mem     (addr_mem),
        .wdata_mem    (wdata_mem),
        .flush        (flush),
        .stall_mem    (stall_mem),
        .addr_err     (addr_err),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // One cycle: drive just after the rising edge, sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one op through the DUT while playing the bus slave; expectations come
    // from byte-lane arithmetic on the op.
    task automatic do_txn(input logic [2:0] op, input logic uns, input logic [31:0] addr,
                          input logic [31:0] src, input logic [31:0] rdata,
                          input int a_dly, input int d_dly, input string tag);
        int          nb;
        int          off;
        logic        st;
        logic        err;
        logic [1:0]  e_sz;
        logic [3:0]  e_strb;
        logic [31:0] e_wd;
        logic [31:0] e_ld;
        logic [63:0] raw;
        logic [63:0] mask;
        nb   = 1 << (int'(op[1:0]) - 1);
        off  = int'(addr[1:0]);
        st   = op[2];
        err  = (off % nb) != 0;
        e_sz = 2'(int'(op[1:0]) - 1);
        e_strb = st ? 4'(((1 << nb) - 1) << off) : 4'b0000;
        if (nb == 1)      e_wd = {24'b0, src[7:0]} * 32'h0101_0101;
        else if (nb == 2) e_wd = {16'b0, src[15:0]} * 32'h0001_0001;
        else              e_wd = src;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        raw  = (64'(rdata) >> (8 * off)) & mask;
        if (!uns && nb != 4 && raw[8*nb-1]) raw = raw | ~mask;
        e_ld = raw[31:0];

        step();
        op_mem = op; unsigned_mem = uns; addr_mem = addr; wdata_mem = src;
        flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        checks++;
        if (addr_err !== err) begin
            failures++; $display("FAIL %s addr_err: got %b want %b", tag, addr_err, err);
        end
        checks++;
        if (stall_mem !== !err) begin
            failures++; $display("FAIL %s start_stall: got %b want %b", tag, stall_mem, !err);
        end
        if (err) begin
            step(); #1;
            checks++;
            if ({data_req, stall_mem} !== 2'b00) begin
                failures++; $display("FAIL %s misaligned_noreq: got req/stall=%b want 00", tag, {data_req, stall_mem});
            end
            op_mem = 3'b000;
            return;
        end

        for (int i = 0; i <= a_dly; i++) begin
            step();
            data_addr_ok = (i == a_dly);
            data_data_ok = (i == a_dly) && (d_dly == 0);
            data_rdata   = data_data_ok ? rdata : $urandom();
            #1;
            checks++;
            if ({data_req, stall_mem, data_wr} !== {1'b1, 1'b1, st}) begin
                failures++; $display("FAIL %s req_ctl[%0d]: got req/stall/wr=%b want %b", tag, i, {data_req, stall_mem, data_wr}, {1'b1, 1'b1, st});
            end
            checks++;
            if ({data_addr, data_size, data_wstrb} !== {addr, e_sz, e_strb}) begin
                failures++; $display("FAIL %s req_fields[%0d]: got addr=%h size=%0d wstrb=%b want addr=%h size=%0d wstrb=%b", tag, i, data_addr, data_size, data_wstrb, addr, e_sz, e_strb);
            end
            if (st) begin
                checks++;
                if (data_wdata !== e_wd) begin
                    failures++; $display("FAIL %s wdata[%0d]: got %h want %h", tag, i, data_wdata, e_wd);
                end
            end
        end

        for (int i = 1; i <= d_dly; i++) begin
            step();
            data_addr_ok = 1'b0;
            data_data_ok = (i == d_dly);
            data_rdata   = data_data_ok ? rdata : $urandom();
            #1;
            checks++;
            if ({data_req, stall_mem} !== 2'b01) begin
                failures++; $display("FAIL %s wait[%0d]: got req/stall=%b want 01", tag, i, {data_req, stall_mem});
            end
        end

        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        checks++;
        if ({stall_mem, load_valid} !== {1'b0, !st}) begin
            failures++; $display("FAIL %s done: got stall/load_valid=%b want %b", tag, {stall_mem, load_valid}, {1'b0, !st});
        end
        if (!st) begin
            checks++;
            if (load_data !== e_ld) begin
                failures++; $display("FAIL %s load_data: got %h want %h", tag, load_data, e_ld);
            end
        end

        step();
        op_mem = 3'b000;
        #1;
        checks++;
        if ({load_valid, stall_mem, data_req} !== 3'b000) begin
            failures++; $display("FAIL %s after_done: got lv/stall/req=%b want 000", tag, {load_valid, stall_mem, data_req});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; op_mem = 3'b000; unsigned_mem = 1'b0; addr_mem = '0; wdata_mem = '0;
        flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        step(); step();
        rst = 1'b0;
        #1;
        checks++;
        if ({stall_mem, addr_err, load_valid, load_data, data_req, data_wr, data_size,
             data_addr, data_wstrb, data_wdata} !== '0) begin
            failures++; $display("FAIL reset_outputs: got req=%b addr=%h wdata=%h ld=%h stall=%b, want all zero", data_req, data_addr, data_wdata, load_data, stall_mem);
        end
    endtask

    task automatic test_store_word();
        do_txn(3'b111, 1'b0, 32'h0000_0100, 32'h1234_5678, 32'h0, 0, 1, "sw");
        checks++;
        if ({data_wstrb, data_wr, data_size, data_wdata} !== {4'b1111, 1'b1, 2'd2, 32'h1234_5678}) begin
            failures++; $display("FAIL sw_fields: got wstrb=%b wr=%b size=%0d wdata=%h want 1111 1 2 12345678", data_wstrb, data_wr, data_size, data_wdata);
        end
    endtask

    task automatic test_load_byte();
        do_txn(3'b001, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_FF00, 0, 1, "lb");
        checks++;
        if (load_data !== 32'hFFFF_FF80) begin
            failures++; $display("FAIL lb_value: got %h want ffffff80", load_data);
        end
        do_txn(3'b001, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_FF00, 0, 1, "lbu");
        checks++;
        if (load_data !== 32'h0000_0080) begin
            failures++; $display("FAIL lbu_value: got %h want 00000080", load_data);
        end
    endtask

    task automatic test_store_half();
        do_txn(3'b110, 1'b0, 32'h0000_0102, 32'h0000_BEEF, 32'h0, 0, 1, "sh");
        checks++;
        if ({data_wstrb, data_size, data_wdata} !== {4'b1100, 2'd1, 32'hBEEF_BEEF}) begin
            failures++; $display("FAIL sh_fields: got wstrb=%b size=%0d wdata=%h want 1100 1 beefbeef", data_wstrb, data_size, data_wdata);
        end
    endtask

    task automatic test_misaligned();
        do_txn(3'b010, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 0, 1, "lh_mis");
        do_txn(3'b111, 1'b0, 32'h0000_0202, 32'hAAAA_5555, 32'h0, 0, 1, "sw_mis");
    endtask

    // Slow slave: addr_ok withheld for 5 cycles, data_ok 2 cycles later.
    task automatic test_addr_wait();
        do_txn(3'b011, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 5, 2, "lw_slow");
        do_txn(3'b010, 1'b0, 32'h0000_0302, 32'h0, 32'h8001_7FFF, 0, 0, "lh_sameok");
    endtask

    task automatic test_flush_req();
        step();
        op_mem = 3'b011; unsigned_mem = 1'b0; addr_mem = 32'h0000_0400; flush = 1'b0;
        #1;
        for (int i = 1; i <= 3; i++) begin
            step();
            if (i == 3) flush = 1'b1;
            #1;
            checks++;
            if ({data_req, stall_mem, data_addr} !== {1'b1, 1'b1, 32'h0000_0400}) begin
                failures++; $display("FAIL flush_req_hold[%0d]: got req=%b stall=%b addr=%h want 1 1 00000400", i, data_req, stall_mem, data_addr);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            flush = 1'b0; op_mem = 3'b000;
            #1;
            checks++;
            if ({data_req, stall_mem, load_valid} !== 3'b000) begin
                failures++; $display("FAIL flush_req_idle[%0d]: got req/stall/lv=%b want 000", i, {data_req, stall_mem, load_valid});
            end
        end
    endtask

    task automatic test_flush_wait();
        step();
        op_mem = 3'b011; addr_mem = 32'h0000_0500; flush = 1'b0;
        #1;
        step();
        data_addr_ok = 1'b1;
        #1;
        step();
        data_addr_ok = 1'b0; flush = 1'b1; op_mem = 3'b000;
        #1;
        checks++;
        if ({data_req, stall_mem} !== 2'b01) begin
            failures++; $display("FAIL flush_wait_stall: got req/stall=%b want 01", {data_req, stall_mem});
        end
        step();
        flush = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1357_9BDF;
        #1;
        checks++;
        if (stall_mem !== 1'b1) begin
            failures++; $display("FAIL flush_wait_pending: got stall=%b want 1", stall_mem);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            data_data_ok = 1'b0;
            #1;
            checks++;
            if ({load_valid, stall_mem, data_req} !== 3'b000) begin
                failures++; $display("FAIL flush_wait_discard[%0d]: got lv/stall/req=%b want 000", i, {load_valid, stall_mem, data_req});
            end
        end
        do_txn(3'b011, 1'b0, 32'h0000_0504, 32'h0, 32'h2468_ACE0, 0, 1, "lw_after_flush");
    endtask

    task automatic test_reset_mid();
        step();
        op_mem = 3'b011; addr_mem = 32'h0000_0600; flush = 1'b0;
        #1;
        step();
        data_addr_ok = 1'b1;
        #1;
        step();
        data_addr_ok = 1'b0; rst = 1'b1;
        #1;
        step();
        rst = 1'b0; op_mem = 3'b000;
        #1;
        checks++;
        if ({stall_mem, addr_err, load_valid, load_data, data_req, data_wr, data_size,
             data_addr, data_wstrb, data_wdata} !== '0) begin
            failures++; $display("FAIL rst_mid_outputs: got req=%b addr=%h ld=%h stall=%b, want all zero", data_req, data_addr, load_data, stall_mem);
        end
        step();
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        #1;
        step();
        data_data_ok = 1'b0;
        #1;
        checks++;
        if ({load_valid, stall_mem, data_req, load_data} !== {3'b000, 32'h0}) begin
            failures++; $display("FAIL rst_mid_late_ok: got lv=%b stall=%b req=%b ld=%h want 0 0 0 0", load_valid, stall_mem, data_req, load_data);
        end
        do_txn(3'b101, 1'b0, 32'h0000_0611, 32'h0000_00A5, 32'h0, 1, 1, "sb_after_rst");
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] addr;
        int          nb;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: op = 3'b001;
                1: op = 3'b010;
                2: op = 3'b011;
                3: op = 3'b101;
                4: op = 3'b110;
                default: op = 3'b111;
            endcase
            nb   = 1 << (int'(op[1:0]) - 1);
            addr = $urandom();
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nb - 1);
            do_txn(op, 1'($urandom_range(0, 1)), addr, $urandom(), $urandom(),
                   $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_addr_wait();
        test_flush_req();
        test_flush_wait();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
